// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a show-ahead FIFO and sends each word as an asynchronous UART frame:
// one start bit (low), DATA_WIDTH data bits LSB first, an optional even-parity
// bit, then STOP_BITS stop bits (high). A word is popped only while idle, so
// the FIFO read strobe doubles as the flow-control handshake.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   reset      : synchronous, active-high reset
//   enable     : allows new frames to start; a frame in flight always finishes
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head word, valid whenever fifo_empty is low
//   fifo_rd_en : one-cycle pop strobe (combinational)
//   tx         : registered serial line, idle high
//   busy       : high while a frame is in progress
//   frame_done : one-cycle pulse in the idle cycle that follows the last stop bit
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  baud_wrap;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction

    assign fifo_rd_en = (state_q == IDLE) && enable && !fifo_empty && !reset;
    assign baud_wrap  = (baud_q == BAUD_LAST);

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

    // The next line level is decided one edge ahead, so tx_q only ever
    // changes on the edge that starts a new bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (fifo_rd_en) begin
                    state_d = START;
                    shreg_d = fifo_data;
                    par_d   = even_parity(fifo_data);
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                // bit_q counts stop bits here so two stop bits reuse the same counter
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. Three instances share clk/reset/enable:
//   u0: CPB=4, 8 data bits, no parity, 1 stop  (frame 40 cycles)
//   u1: CPB=4, 8 data bits, even parity, 1 stop (frame 44 cycles)
//   u2: CPB=4, 8 data bits, no parity, 2 stops  (frame 44 cycles)
// Each instance has its own FIFO model. Outputs are predicted from the frame
// bit list and the time elapsed since the pop.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       empt   [3];
    logic [7:0] fdata  [3];
    logic       rd     [3];
    logic       txo    [3];
    logic       bsy    [3];
    logic       dn     [3];

    // FIFO models driven by the stimulus process
    logic [7:0] fmem [3][16];
    logic [3:0] wp   [3];
    logic [3:0] rp   [3];
    int         cnt  [3];
    logic       popnow [3];

    // reference model state, owned by the compare process
    logic       act    [3];
    int         k      [3];
    logic       done_m [3];
    logic [7:0] word   [3];
    int         pop_c  [3];
    int         brun   [3];
    int         LEN    [3] = '{40, 44, 44};

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(empt[0]), .fifo_data(fdata[0]),
        .fifo_rd_en(rd[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(dn[0])
    );
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(empt[1]), .fifo_data(fdata[1]),
        .fifo_rd_en(rd[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(dn[1])
    );
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(empt[2]), .fifo_data(fdata[2]),
        .fifo_rd_en(rd[2]), .tx(txo[2]), .busy(bsy[2]), .frame_done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pen_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int nbits(input int i);
        return 1 + 8 + pen_of(i) + ((i == 2) ? 2 : 1);
    endfunction

    // Line level of frame bit idx: start, 8 data bits LSB first, parity, stops.
    function automatic logic fbit(input logic [7:0] w, input int pen, input int idx);
        logic [7:0] s;
        if (idx == 0) return 1'b0;
        if (idx <= 8) begin
            s = w >> (idx - 1);
            return s[0];
        end
        if (pen != 0 && idx == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int idx, input int act_v, input int exp_v);
        n_chk++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s[u%0d] at cycle %0d: got %0d, expected %0d", nm, idx, cyc, act_v, exp_v);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic refresh();
        for (int i = 0; i < 3; i++) begin
            empt[i]  = (cnt[i] == 0);
            fdata[i] = (cnt[i] != 0) ? fmem[i][rp[i]] : 8'h00;
        end
    endtask

    task automatic push_all(input logic [7:0] w);
        for (int i = 0; i < 3; i++) begin
            if (cnt[i] < 16) begin
                fmem[i][wp[i]] = w;
                wp[i] = wp[i] + 4'd1;
                cnt[i]++;
            end
        end
        refresh();
    endtask

    // One clock: capture the pop strobes before the edge, retire the head after it.
    task automatic tick();
        @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) popnow[i] = rd[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (popnow[i] && cnt[i] > 0) begin
                rp[i] = rp[i] + 4'd1;
                cnt[i]--;
            end
        end
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin : stim
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wp[i] = '0; rp[i] = '0; cnt[i] = 0; popnow[i] = 1'b0;
        end
        refresh();
        run(3);
        reset = 1'b0;
        run(3);

        // enable low with data waiting: nothing may leave
        push_all(8'hA5);
        run(10);
        enable = 1'b1;
        run(50);

        // back-to-back words
        push_all(8'h00);
        push_all(8'hFF);
        run(100);

        // parity patterns
        push_all(8'h07);
        push_all(8'h03);
        run(100);

        push_all(8'h55);
        run(50);

        // drop enable mid-frame, then restore it
        push_all(8'h3C);
        push_all(8'hC3);
        run(10);
        enable = 1'b0;
        run(60);
        enable = 1'b1;
        run(100);

        // reset during data bit 3 (pop edge follows the first tick)
        push_all(8'h96);
        run(18);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_all(8'h69);
        run(60);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3, 0) == 0) push_all(8'($urandom));
            if ($urandom_range(49, 0) == 0) enable = ~enable;
            if ($urandom_range(299, 0) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        enable = 1'b1;
        run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    // ---------------- compare ----------------
    initial begin : compare
        logic [9:0] v;
        logic       ex_tx;
        logic       ex_rd;

        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0; k[i] = 0; done_m[i] = 1'b0; word[i] = '0;
            pop_c[i] = -1000; brun[i] = 0;
        end

        // pin the model against hand-derived values
        v = '0;
        for (int b = 0; b < 10; b++) v = {fbit(8'hA5, 0, b), v[9:1]};
        chk("model_a5_bits", 0, int'(v), int'(10'b1101001010));
        chk("model_par_07", 1, int'(fbit(8'h07, 1, 9)), 1);
        chk("model_par_03", 1, int'(fbit(8'h03, 1, 9)), 0);
        for (int i = 0; i < 3; i++) chk("model_len", i, nbits(i) * CPB, LEN[i]);

        // first edge is taken with reset high, so the model starts idle
        @(negedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                ex_tx = act[i] ? fbit(word[i], pen_of(i), k[i] / CPB) : 1'b1;
                ex_rd = !act[i] && enable && !empt[i] && !reset;
                chk("tx",         i, int'(txo[i]), int'(ex_tx));
                chk("busy",       i, int'(bsy[i]), int'(act[i]));
                chk("frame_done", i, int'(dn[i]),  int'(done_m[i]));
                chk("fifo_rd_en", i, int'(rd[i]),  int'(ex_rd));

                // frame-level timing as seen on the DUT pins
                if (bsy[i]) brun[i]++;
                if (dn[i]) begin
                    chk("frame_len", i, cyc - pop_c[i] - 1, LEN[i]);
                    chk("busy_len",  i, brun[i], LEN[i]);
                    if (rd[i]) chk("b2b_period", i, cyc - pop_c[i], LEN[i] + 1);
                    brun[i] = 0;
                end
                if (rd[i]) begin
                    pop_c[i] = cyc;
                    brun[i]  = 0;
                end

                // advance the model across the coming edge
                done_m[i] = 1'b0;
                if (reset) begin
                    act[i] = 1'b0;
                end else if (act[i]) begin
                    k[i]++;
                    if (k[i] == nbits(i) * CPB) begin
                        act[i]    = 1'b0;
                        done_m[i] = 1'b1;
                    end
                end else if (ex_rd) begin
                    act[i]  = 1'b1;
                    k[i]    = 0;
                    word[i] = fdata[i];
                end
            end
        end
    end

endmodule
